// File: rtl/key_debounce_bank.sv
// key_debounce_bank
//   N-channel push-button / switch conditioner. Each channel runs a two-flop
//   synchroniser, polarity normalisation, a stability counter and a state
//   register. It emits a clean level plus one-cycle press/release pulses.
//   Optional feature macro: DEBOUNCE_REPEAT_EN. When it is defined, each channel
//   also gets an auto-repeat engine that drives o_repeat. When it is not
//   defined, o_repeat is tied low and REPEAT_DELAY/REPEAT_PERIOD are only
//   range-checked.
module key_debounce_bank #(
   parameter int N_CH          = 4,
   parameter int STABLE_CYCLES = 500000,
   parameter bit ACTIVE_LOW    = 1'b1,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [N_CH-1:0] i_in,
   output logic [N_CH-1:0] o_level,
   output logic [N_CH-1:0] o_press,
   output logic [N_CH-1:0] o_release,
   output logic [N_CH-1:0] o_repeat
);

   localparam int               CNT_W      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
   // Raw pin level of a released key; the synchroniser starts here so that
   // leaving reset with idle inputs produces no spurious edge.
   localparam logic             IDLE_LEVEL = ACTIVE_LOW;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int               RPT_W       = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_DELAY,
      RPT_REPEAT
   } rpt_state_e;
`endif

   // Reject parameter sets the counters cannot represent.
   if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
      $error("key_debounce_bank: illegal STABLE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic             sync1_q;
      logic             sync2_q;
      logic             sample;
      logic             accept;
      logic             state_q,   state_d;
      logic [CNT_W-1:0] cnt_q,     cnt_d;
      logic             press_q,   press_d;
      logic             release_q, release_d;

      // Bring the asynchronous pin into the clock domain.
      always_ff @(posedge i_clk or posedge i_rst) begin
         // NOTE: flops use non-blocking assignments so that every register
         // samples the pre-edge value of its neighbour (sync2 gets old sync1).
         if (i_rst) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
         end else begin
            sync1_q <= i_in[ch];
            sync2_q <= sync1_q;
         end
      end

      // 1 = pressed, regardless of board polarity.
      assign sample = sync2_q ^ ACTIVE_LOW;
      assign accept = (sample != state_q) && (cnt_q == CNT_LAST);

      // Stability counter: count while the sample disagrees with the state,
      // accept after STABLE_CYCLES consecutive disagreeing edges.
      always_comb begin
         // NOTE: every output of this block gets a default first, so no path
         // leaves a variable unassigned and no latch is inferred.
         state_d   = state_q;
         cnt_d     = '0;
         press_d   = 1'b0;
         release_d = 1'b0;
         if (sample != state_q) begin
            if (accept) begin
               state_d   = sample;
               press_d   = sample;
               release_d = ~sample;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      // Debounce state, counter and registered pulses.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            state_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
         end
      end

      assign o_level[ch]   = state_q;
      assign o_press[ch]   = press_q;
      assign o_release[ch] = release_q;

`ifdef DEBOUNCE_REPEAT_EN
      rpt_state_e       rpt_state_q, rpt_state_d;
      logic [RPT_W-1:0] rpt_cnt_q,   rpt_cnt_d;
      logic             rpt_q,       rpt_d;

      // Repeat FSM state, counter and registered pulse.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= '0;
            rpt_q       <= 1'b0;
         end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_q       <= rpt_d;
         end
      end

      // Repeat next-state: an accepted release always wins over a due pulse.
      always_comb begin
         rpt_state_d = rpt_state_q;
         rpt_cnt_d   = rpt_cnt_q;
         rpt_d       = 1'b0;
         unique case (rpt_state_q)
            RPT_IDLE: begin
               if (accept && sample) begin
                  rpt_state_d = RPT_DELAY;
                  rpt_cnt_d   = '0;
               end
            end
            RPT_DELAY: begin
               if (accept && !sample) begin
                  rpt_state_d = RPT_IDLE;
                  rpt_cnt_d   = '0;
               end else if (rpt_cnt_q == DELAY_LAST) begin
                  rpt_state_d = RPT_REPEAT;
                  rpt_cnt_d   = '0;
                  rpt_d       = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
               end
            end
            RPT_REPEAT: begin
               if (accept && !sample) begin
                  rpt_state_d = RPT_IDLE;
                  rpt_cnt_d   = '0;
               end else if (rpt_cnt_q == PERIOD_LAST) begin
                  rpt_cnt_d = '0;
                  rpt_d     = 1'b1;
               end else begin
                  rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
               end
            end
            default: begin
               rpt_state_d = RPT_IDLE;
               rpt_cnt_d   = '0;
            end
         endcase
      end

      assign o_repeat[ch] = rpt_q;
`else
      assign o_repeat[ch] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Testbench for key_debounce_bank (N_CH=4, STABLE_CYCLES=8, ACTIVE_LOW=1,
// REPEAT_DELAY=20, REPEAT_PERIOD=5). Edge n is the n-th rising clock edge.
// Stimulus pushes expected pulse events into a queue. A negedge monitor pops
// one event for every cycle with any pulse high and compares edge number and
// pulse vectors. Repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_key_debounce_bank;

   localparam int N_CH = 4;

   logic            clk    = 1'b0;
   logic            rst    = 1'b0;
   logic [N_CH-1:0] in_raw = '1;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] rel;
   logic [N_CH-1:0] rpt;

   int edge_cnt = 0;
   int tests    = 0;
   int errors   = 0;

   typedef struct {
      int         at;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] rpt;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   key_debounce_bank #(
      .N_CH          (N_CH),
      .STABLE_CYCLES (8),
      .ACTIVE_LOW    (1'b1),
      .REPEAT_DELAY  (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_in      (in_raw),
      .o_level   (level),
      .o_press   (press),
      .o_release (rel),
      .o_repeat  (rpt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, req);
      end
   endtask

   task automatic expect_pulse(input int at, input logic [3:0] p, input logic [3:0] r,
                               input logic [3:0] t);
      exp_t e;
      e.at    = at;
      e.press = p;
      e.rel   = r;
      e.rpt   = t;
      sb.push_back(e);
   endtask

   // Return at the falling edge that follows rising edge n.
   task automatic at_edge(input int n);
      while (edge_cnt < n) @(negedge clk);
   endtask

   // Monitor: every cycle carrying a pulse must match the next expected event.
   always @(negedge clk) begin
      if ((press | rel | rpt) != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {20'h0, press, rel, rpt}, 32'h0);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_edge",   edge_cnt, mon_e.at);
            check("press_vec",    press,    mon_e.press);
            check("release_vec",  rel,      mon_e.rel);
            check("repeat_vec",   rpt,      mon_e.rpt);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("reset_level",  level, 4'h0);
      check("reset_pulses", {press, rel, rpt}, 12'h0);
      at_edge(2);
      rst = 1'b0;

      // Clean press on channel 0: driven before edge 10, accepted at edge 19.
      at_edge(9);
      in_raw[0] = 1'b0;
      expect_pulse(19, 4'h1, 4'h0, 4'h0);
      at_edge(18);
      check("ch0_level_before", level, 4'h0);
      at_edge(19);
      check("ch0_level_after", level, 4'h1);
      at_edge(24);
      in_raw[0] = 1'b1;
      expect_pulse(34, 4'h0, 4'h1, 4'h0);
      at_edge(34);
      check("ch0_level_released", level, 4'h0);

      // Bounce on channel 1: toggles every 3 cycles, last toggle to 0 before
      // edge 71, so a single press at edge 80.
      for (int i = 0; i <= 10; i++) begin
         at_edge(40 + 3 * i);
         in_raw[1] = ~in_raw[1];
      end
      expect_pulse(80, 4'h2, 4'h0, 4'h0);
      at_edge(79);
      check("ch1_level_in_bounce", level, 4'h0);
      at_edge(85);
      in_raw[1] = 1'b1;
      expect_pulse(95, 4'h0, 4'h2, 4'h0);

      // Auto-repeat on channel 2: press at 110, repeats at 130/135/140.
      // The release is accepted at 145, the same edge a repeat would be due.
      at_edge(100);
      in_raw[2] = 1'b0;
      expect_pulse(110, 4'h4, 4'h0, 4'h0);
`ifdef DEBOUNCE_REPEAT_EN
      expect_pulse(130, 4'h0, 4'h0, 4'h4);
      expect_pulse(135, 4'h0, 4'h0, 4'h4);
      expect_pulse(140, 4'h0, 4'h0, 4'h4);
`endif
      at_edge(135);
      in_raw[2] = 1'b1;
      expect_pulse(145, 4'h0, 4'h4, 4'h0);
      at_edge(144);
      check("ch2_level_held", level, 4'h4);
      at_edge(145);
      check("ch2_level_released", level, 4'h0);

      // All channels pressed together, then released one cycle apart.
      at_edge(160);
      in_raw = 4'h0;
      expect_pulse(170, 4'hF, 4'h0, 4'h0);
      for (int c = 0; c < N_CH; c++) begin
         at_edge(175 + c);
         in_raw[c] = 1'b1;
         expect_pulse(185 + c, 4'h0, 4'(1 << c), 4'h0);
      end
      at_edge(170);
      check("all_level_pressed", level, 4'hF);
      at_edge(188);
      check("all_level_released", level, 4'h0);

      // Reset while channel 2 repeats and channel 3 is mid-count.
      at_edge(200);
      in_raw[2] = 1'b0;
      expect_pulse(210, 4'h4, 4'h0, 4'h0);
`ifdef DEBOUNCE_REPEAT_EN
      expect_pulse(230, 4'h0, 4'h0, 4'h4);
`endif
      at_edge(231);
      in_raw[3] = 1'b0;
      at_edge(233);
      check("pre_reset_level", level, 4'h4);
      #2 rst = 1'b1;
      #1;
      check("mid_reset_level",  level, 4'h0);
      check("mid_reset_pulses", {press, rel, rpt}, 12'h0);
      in_raw[3] = 1'b1;
      at_edge(236);
      rst = 1'b0;
      // Channel 2 held across reset release: fresh press at edge 237 + 9.
      expect_pulse(246, 4'h4, 4'h0, 4'h0);
      at_edge(245);
      check("post_reset_level_before", level, 4'h0);
      at_edge(246);
      check("post_reset_level_after", level, 4'h4);
      at_edge(250);
      in_raw[2] = 1'b1;
      expect_pulse(260, 4'h0, 4'h4, 4'h0);

      at_edge(280);
      check("final_level", level, 4'h0);
      check("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/key_debounce_bank.md
# key_debounce_bank

Multi-channel debouncer and edge detector for the board push-buttons and switches; generalises the single-key debouncer to N channels with configurable polarity, stable-time and optional auto-repeat. Sits between raw board pins (KEY/SW) and user logic on the system clock. Each channel delivers a clean level plus single-cycle press/release pulses, and optionally repeat pulses while held.

## Interface
- N_CH, 4, number of independent channels
- STABLE_CYCLES, 500000, consecutive cycles a new raw level must persist before acceptance (>= 2)
- ACTIVE_LOW, 1, 1: raw 0 means pressed (DE2-115 KEY); 0: raw 1 means pressed
- REPEAT_DELAY, 25000000, cycles from accepted press to first repeat pulse (>= 1)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>= 1)
- i_clk  in  1  system clock (50 MHz)
- i_rst  in  1  reset, asynchronous, active-high
- i_in  in  N_CH  raw asynchronous inputs, one bit per channel
- o_level  out  N_CH  debounced pressed state (1 = pressed)
- o_press  out  N_CH  one-cycle pulse on accepted press
- o_release  out  N_CH  one-cycle pulse on accepted release
- o_repeat  out  N_CH  one-cycle auto-repeat pulse while held

## Operation
- Per channel, fully independent: 2-flop synchroniser -> polarity normalise (invert when ACTIVE_LOW) -> stability counter -> state register -> pulse generation.
- Stability counter width $clog2(STABLE_CYCLES). Each edge: if normalised sample != state, counter increments; if equal, counter clears to 0.
- Acceptance: on an edge where sample != state and counter == STABLE_CYCLES-1, state <= sample, counter <= 0, and o_press (new state 1) or o_release (new state 0) asserts for that one cycle.
- A glitch or bounce shorter than STABLE_CYCLES consecutive cycles never changes state; any reversion restarts the count from 0.
- Repeat engine (only with macro, see Configuration), per channel states IDLE, DELAY, REPEAT:
  - IDLE -> DELAY on accepted press; repeat counter loads 0.
  - DELAY: counter increments; at count REPEAT_DELAY-1 pulse o_repeat, counter <= 0, go REPEAT.
  - REPEAT: counter increments; at REPEAT_PERIOD-1 pulse o_repeat, counter <= 0, stay.
  - Accepted release from DELAY/REPEAT -> IDLE same edge; no o_repeat on that edge.
  - Repeat counter width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- o_press never coincides with o_repeat; o_press and o_release never both high on one channel.

## Timing
- Raw input settles before edge k (first sampling edge): synchroniser output valid after edge k+1; o_level and the press/release pulse update at edge k+1+STABLE_CYCLES.
- First o_repeat at edge REPEAT_DELAY after the o_press edge; subsequent ones every REPEAT_PERIOD edges.
- All outputs registered; no combinational path from i_in.
- Reset (any time, including mid-count or mid-repeat): synchroniser flops to raw idle level (1 if ACTIVE_LOW, else 0), state 0, all counters 0, repeat FSM IDLE, o_level/o_press/o_release/o_repeat = 0. No pulses generated on reset release if inputs are idle; a button held through reset release is accepted as a fresh press after the normal latency.

## Configuration
- DEBOUNCE_REPEAT_EN defined: repeat FSM and counters built per channel, o_repeat behaves as above.
- Not defined: no repeat logic synthesised, o_repeat tied to 0; REPEAT_DELAY/REPEAT_PERIOD ignored. All other behaviour identical.

## Test plan
Bench parameters: N_CH=4, STABLE_CYCLES=8, ACTIVE_LOW=1, REPEAT_DELAY=20, REPEAT_PERIOD=5, macro defined unless noted.
- Clean press: i_in[0] 1->0 before edge 10 -> o_press[0] high exactly at edge 19 for one cycle, o_level[0]=1 from edge 19; other channels quiet.
- Bounce: i_in[1] toggles every 3 cycles for 30 cycles then holds 0 -> single o_press[1] 9 edges after final toggle; no pulses during bounce.
- Repeat: hold i_in[2]=0 -> o_press at P, o_repeat at P+20, P+25, P+30; release -> o_release after 9 edges, no further o_repeat.
- Simultaneous: all four channels pressed on same edge -> o_press=4'hF on one cycle; releases staggered by 1 cycle each produce distinct single pulses.
- Reset mid-operation: assert i_rst during repeat and mid-count on another channel -> all outputs 0 asynchronously; key held across release -> o_press 9 edges after i_rst deasserts.
- Macro undefined: repeat scenario yields o_press/o_release as before, o_repeat constantly 0.
